// File: rtl/div2_engine_if.sv
// Launch/done handshake and byte-wide data-memory port of the div2 engine.
// The engine drives through master; the host and memory sit on slave.
interface div2_engine_if;
    logic       Start;
    logic       Ack;
    logic [7:0] MemAddr;
    logic [7:0] MemRdData;
    logic       MemWrEn;
    logic [7:0] MemWrData;

    modport master (
        input  Start,
        input  MemRdData,
        output Ack,
        output MemAddr,
        output MemWrEn,
        output MemWrData
    );

    modport slave (
        output Start,
        output MemRdData,
        input  Ack,
        input  MemAddr,
        input  MemWrEn,
        input  MemWrData
    );
endinterface

// File: rtl/div2_engine.sv
// Memory-attached 16x8 fractional divider: Q = floor(dividend*256/divisor).
// Restoring, MSB-first, one quotient bit per cycle over {dividend, 8'h00}.
module div2_engine (
    input  logic           Clk,
    input  logic           Reset,
    div2_engine_if.master  bus
);

    typedef enum logic [3:0] {
        IDLE, LD0, LD1, LD2, DIV, ST0, ST1, ST2, DONE
    } state_t;

    state_t      state;
    state_t      state_n;
    logic        start_q;
    logic        ack_q;
    logic [23:0] num;
    logic [8:0]  rem;
    logic [7:0]  dvsr;
    logic [4:0]  cnt;

    logic [8:0]  rem_sh;
    logic [8:0]  rem_d;
    logic        q_bit;
    logic        launch;
    logic        rearm;

    logic [7:0]  addr;
    logic        wr_en;
    logic [7:0]  wr_data;

    assign launch = start_q && !bus.Start;
    assign rearm  = !start_q && bus.Start;

    // rem[8] is never set in practice; folding it in keeps the step exact
    assign rem_sh = {rem[7:0], num[23]};
    assign q_bit  = rem[8] || (rem_sh >= {1'b0, dvsr});
    assign rem_d  = q_bit ? rem_sh - {1'b0, dvsr} : rem_sh;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            start_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state   <= state_n;
            start_q <= bus.Start;
            ack_q   <= (state_n == DONE);
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (launch) state_n = LD0;
            LD0:  state_n = LD1;
            LD1:  state_n = LD2;
            LD2:  state_n = (bus.MemRdData == 8'h00) ? ST0 : DIV;
            DIV:  if (cnt == 5'd23) state_n = ST0;
            ST0:  state_n = ST1;
            ST1:  state_n = ST2;
            ST2:  state_n = DONE;
            DONE: if (rearm) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        addr    = 8'd0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        unique case (state)
            LD0: addr = 8'd0;
            LD1: addr = 8'd1;
            LD2: addr = 8'd2;
            ST0: begin
                addr    = 8'd4;
                wr_en   = 1'b1;
                wr_data = num[23:16];
            end
            ST1: begin
                addr    = 8'd5;
                wr_en   = 1'b1;
                wr_data = num[15:8];
            end
            ST2: begin
                addr    = 8'd6;
                wr_en   = 1'b1;
                wr_data = num[7:0];
            end
            default: ;
        endcase
    end

    // num holds the numerator and fills with quotient bits as it shifts
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            num  <= 24'h0;
            rem  <= 9'h0;
            dvsr <= 8'h0;
            cnt  <= 5'd0;
        end else begin
            unique case (state)
                LD0: num[23:16] <= bus.MemRdData;
                LD1: num[15:0]  <= {bus.MemRdData, 8'h00};
                LD2: begin
                    dvsr <= bus.MemRdData;
                    rem  <= 9'h0;
                    cnt  <= 5'd0;
                    if (bus.MemRdData == 8'h00) num <= 24'hFFFFFF;
                end
                DIV: begin
                    num <= {num[22:0], q_bit};
                    rem <= rem_d;
                    cnt <= cnt + 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.Ack       = ack_q;
    assign bus.MemAddr   = addr;
    assign bus.MemWrEn   = wr_en;
    assign bus.MemWrData = wr_data;

endmodule
